// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the two-port memory arbiter.
// Holds the arbiter state encoding and the default widths/watchdog limit.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DM_XFER = 2'd1,
    IF_XFER = 2'd2
  } state_t;

  localparam int DEF_ADDR_W         = 32;
  localparam int DEF_DATA_W         = 32;
  localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch port, data port, shared memory port and stall line.
// slave = arbiter view; master = requesters plus memory, as seen from outside.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_ack_o;

  logic              dm_req_i;
  logic              dm_we_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              dm_ack_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ack_i;

  logic              stall_o;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_rdata_o, if_ack_o,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    output dm_rdata_o, dm_ack_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i,
    output stall_o
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_rdata_o, if_ack_o,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    input  dm_rdata_o, dm_ack_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i,
    input  stall_o
  );

endinterface

// File: rtl/mem_arb_watchdog.sv
// Transfer watchdog: counts enabled cycles, pulses expire_o on the LIMIT-th one.
// Combinational expire, no backpressure; clr_i wins over en_i.
module mem_arb_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire_o = en_i && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority (data over fetch) arbiter onto one memory port, one transfer in flight; ack_o two edges after req.
// Requesters are held via stall_o until their ack; MEM_ARB_TIMEOUT_EN adds a watchdog and sticky err_o.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic clk_i,
  input logic rst_i,
`ifdef MEM_ARB_TIMEOUT_EN
  output logic err_o,
`endif
  mem_arbiter_if.slave bus
);

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic              expire;
  logic              dm_elig, if_elig;

`ifdef MEM_ARB_TIMEOUT_EN
  logic err_q, err_d;

  mem_arb_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (state_q == IDLE),
    .en_i     (state_q != IDLE),
    .expire_o (expire)
  );

  assign err_d = err_q | (expire & ~bus.mem_ack_i);
  assign err_o = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end
`else
  // Limit only matters with the watchdog compiled in.
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign expire         = 1'b0;
`endif

  // A requester whose ack is showing still holds req; don't serve it twice.
  assign dm_elig = bus.dm_req_i & ~dm_ack_q;
  assign if_elig = bus.if_req_i & ~if_ack_q;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (dm_elig) begin
          state_d     = DM_XFER;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.dm_we_i;
          mem_addr_d  = bus.dm_addr_i;
          mem_wdata_d = bus.dm_wdata_i;
        end else if (if_elig) begin
          state_d     = IF_XFER;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr_i;
          mem_wdata_d = '0;
        end
      end
      DM_XFER: begin
        if (bus.mem_ack_i || expire) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          dm_ack_d  = 1'b1;
          // Writes leave the last read data in place; timeouts return zero.
          if (!bus.mem_ack_i)  dm_rdata_d = '0;
          else if (!mem_we_q)  dm_rdata_d = bus.mem_rdata_i;
        end
      end
      IF_XFER: begin
        if (bus.mem_ack_i || expire) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          if_ack_d   = 1'b1;
          if_rdata_d = bus.mem_ack_i ? bus.mem_rdata_i : '0;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
    end
  end

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.if_ack_o    = if_ack_q;
  assign bus.dm_rdata_o  = dm_rdata_q;
  assign bus.dm_ack_o    = dm_ack_q;
  assign bus.stall_o     = (bus.if_req_i & ~if_ack_q) | (bus.dm_req_i & ~dm_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change and outputs are checked on the falling edge.
// Define MEM_ARB_TIMEOUT_EN to also exercise the watchdog with an 8-cycle limit.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef MEM_ARB_TIMEOUT_EN
  logic err;
`endif

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
`ifdef MEM_ARB_TIMEOUT_EN
    .err_o (err),
`endif
    .bus   (bus)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.if_req_i    = 1'b0;
    bus.if_addr_i   = '0;
    bus.dm_req_i    = 1'b0;
    bus.dm_we_i     = 1'b0;
    bus.dm_addr_i   = '0;
    bus.dm_wdata_i  = '0;
    bus.mem_rdata_i = '0;
    bus.mem_ack_i   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk1 ("rst_mem_req",   bus.mem_req_o,   1'b0);
    chk1 ("rst_mem_we",    bus.mem_we_o,    1'b0);
    chk32("rst_mem_addr",  bus.mem_addr_o,  32'h0);
    chk32("rst_mem_wdata", bus.mem_wdata_o, 32'h0);
    chk32("rst_if_rdata",  bus.if_rdata_o,  32'h0);
    chk32("rst_dm_rdata",  bus.dm_rdata_o,  32'h0);
    chk1 ("rst_if_ack",    bus.if_ack_o,    1'b0);
    chk1 ("rst_dm_ack",    bus.dm_ack_o,    1'b0);
    chk1 ("rst_stall",     bus.stall_o,     1'b0);
    rst = 1'b0;

    // Data read, memory acks in the first request cycle
    @(negedge clk);
    bus.dm_req_i  = 1'b1;
    bus.dm_we_i   = 1'b0;
    bus.dm_addr_i = 32'h10;
    @(negedge clk);
    chk1 ("rd_mem_req",  bus.mem_req_o,  1'b1);
    chk32("rd_mem_addr", bus.mem_addr_o, 32'h10);
    chk1 ("rd_mem_we",   bus.mem_we_o,   1'b0);
    chk1 ("rd_ack_early", bus.dm_ack_o,  1'b0);
    chk1 ("rd_stall",    bus.stall_o,    1'b1);
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 32'hDEADBEEF;
    @(negedge clk);
    chk1 ("rd_dm_ack",   bus.dm_ack_o,   1'b1);
    chk32("rd_dm_rdata", bus.dm_rdata_o, 32'hDEADBEEF);
    chk1 ("rd_req_drop", bus.mem_req_o,  1'b0);
    chk1 ("rd_stall_ack", bus.stall_o,   1'b0);
    bus.mem_ack_i = 1'b0;
    @(negedge clk);
    chk1 ("rd_no_regrant", bus.mem_req_o, 1'b0);
    chk1 ("rd_ack_single", bus.dm_ack_o,  1'b0);
    bus.dm_req_i = 1'b0;

    // Simultaneous data write and fetch: data first
    @(negedge clk);
    bus.dm_req_i   = 1'b1;
    bus.dm_we_i    = 1'b1;
    bus.dm_addr_i  = 32'h20;
    bus.dm_wdata_i = 32'h5;
    bus.if_req_i   = 1'b1;
    bus.if_addr_i  = 32'h8;
    @(negedge clk);
    chk1 ("wr_mem_req",   bus.mem_req_o,   1'b1);
    chk1 ("wr_mem_we",    bus.mem_we_o,    1'b1);
    chk32("wr_mem_addr",  bus.mem_addr_o,  32'h20);
    chk32("wr_mem_wdata", bus.mem_wdata_o, 32'h5);
    chk1 ("wr_stall",     bus.stall_o,     1'b1);
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 32'h12345678;
    @(negedge clk);
    chk1 ("wr_dm_ack",     bus.dm_ack_o,   1'b1);
    chk1 ("wr_if_ack",     bus.if_ack_o,   1'b0);
    chk32("wr_rdata_held", bus.dm_rdata_o, 32'hDEADBEEF);
    chk1 ("wr_stall_if",   bus.stall_o,    1'b1);
    bus.mem_ack_i = 1'b0;
    @(negedge clk);
    chk1 ("fe_mem_req",  bus.mem_req_o,  1'b1);
    chk32("fe_mem_addr", bus.mem_addr_o, 32'h8);
    chk1 ("fe_mem_we",   bus.mem_we_o,   1'b0);
    chk1 ("fe_dm_ack_single", bus.dm_ack_o, 1'b0);
    bus.dm_req_i    = 1'b0;
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 32'hCAFE0001;
    @(negedge clk);
    chk1 ("fe_if_ack",   bus.if_ack_o,   1'b1);
    chk32("fe_if_rdata", bus.if_rdata_o, 32'hCAFE0001);
    chk1 ("fe_stall",    bus.stall_o,    1'b0);
    bus.mem_ack_i = 1'b0;
    bus.if_req_i  = 1'b0;
    @(negedge clk);
    chk1 ("fe_if_ack_single", bus.if_ack_o, 1'b0);
    chk1 ("fe_idle_req",      bus.mem_req_o, 1'b0);

    // Fetch with 3-cycle memory latency, request held through the ack cycle
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h4;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1 ("lat_mem_req",  bus.mem_req_o,  1'b1);
      chk32("lat_mem_addr", bus.mem_addr_o, 32'h4);
      chk1 ("lat_if_ack",   bus.if_ack_o,   1'b0);
    end
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 32'hA5A5A5A5;
    @(negedge clk);
    chk1 ("lat_ack",    bus.if_ack_o,   1'b1);
    chk32("lat_rdata",  bus.if_rdata_o, 32'hA5A5A5A5);
    bus.mem_ack_i = 1'b0;
    @(negedge clk);
    chk1 ("lat_no_regrant", bus.mem_req_o, 1'b0);
    chk1 ("lat_ack_single", bus.if_ack_o,  1'b0);
    bus.if_req_i = 1'b0;

    // Reset during a data transfer, then a stray memory ack
    @(negedge clk);
    bus.dm_req_i  = 1'b1;
    bus.dm_we_i   = 1'b0;
    bus.dm_addr_i = 32'h30;
    @(negedge clk);
    chk1 ("abrt_mem_req", bus.mem_req_o, 1'b1);
    rst          = 1'b1;
    bus.dm_req_i = 1'b0;
    @(negedge clk);
    chk1 ("abrt_mem_req0",  bus.mem_req_o,  1'b0);
    chk32("abrt_mem_addr0", bus.mem_addr_o, 32'h0);
    chk32("abrt_dm_rdata0", bus.dm_rdata_o, 32'h0);
    chk32("abrt_if_rdata0", bus.if_rdata_o, 32'h0);
    rst             = 1'b0;
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 32'hFFFF0000;
    @(negedge clk);
    chk1 ("abrt_no_dm_ack", bus.dm_ack_o, 1'b0);
    chk1 ("abrt_no_if_ack", bus.if_ack_o, 1'b0);
    chk1 ("abrt_idle_req",  bus.mem_req_o, 1'b0);
    bus.mem_ack_i = 1'b0;
    @(negedge clk);
    chk32("abrt_rdata_kept0", bus.dm_rdata_o, 32'h0);

    // Requester drops req mid-transfer; transfer still completes
    bus.dm_req_i  = 1'b1;
    bus.dm_addr_i = 32'h40;
    @(negedge clk);
    chk1 ("drop_mem_req", bus.mem_req_o, 1'b1);
    bus.dm_req_i = 1'b0;
    @(negedge clk);
    chk1 ("drop_req_held", bus.mem_req_o, 1'b1);
    chk1 ("drop_stall",    bus.stall_o,   1'b0);
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 32'h0BADF00D;
    @(negedge clk);
    chk1 ("drop_dm_ack",   bus.dm_ack_o,   1'b1);
    chk32("drop_dm_rdata", bus.dm_rdata_o, 32'h0BADF00D);
    bus.mem_ack_i = 1'b0;

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog: memory never answers
    @(negedge clk);
    chk1 ("to_err_clear", err, 1'b0);
    bus.dm_req_i  = 1'b1;
    bus.dm_addr_i = 32'h50;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk1 ("to_mem_req", bus.mem_req_o, 1'b1);
      if (i == 0) bus.dm_req_i = 1'b0;
    end
    @(negedge clk);
    chk1 ("to_req_drop",  bus.mem_req_o,  1'b0);
    chk1 ("to_dm_ack",    bus.dm_ack_o,   1'b1);
    chk32("to_dm_rdata",  bus.dm_rdata_o, 32'h0);
    chk1 ("to_err",       err,            1'b1);
    repeat (3) @(negedge clk);
    chk1 ("to_err_sticky", err, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk1 ("to_err_reset", err, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
